// File: rtl/spart_tx_buffer.sv
// rtl/spart_tx_buffer.sv - SPART transmit FIFO feeding an 8N1 serializer with programmable bit period
module spart_tx_buffer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             send,
    input  logic [7:0]       send_data,
    output logic             full,
    input  logic [15:0]      baud_div,
    output logic             TxD,
    output logic             tx_busy,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_n;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [CNT_W-1:0]  count_n;
    logic [7:0]        shift, shift_n;
    logic [2:0]        bit_idx, bit_idx_n;
    logic [15:0]       timer, timer_n, period, period_n;
    logic              txd_n, overflow_n, push, pop, bit_end;

    // Flags come only from the registered count, so send never reaches full combinationally.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign tx_busy = (state != IDLE);
    assign push    = send && !full;
    assign pop     = (state == IDLE) && !empty;
    assign bit_end = (timer == period - 16'd1);

    always_comb begin
        state_n    = state;
        shift_n    = shift;
        bit_idx_n  = bit_idx;
        period_n   = period;
        rd_ptr_n   = rd_ptr;
        timer_n    = (state == IDLE) ? timer : timer + 16'd1;
        wr_ptr_n   = push ? wr_ptr + 1'b1 : wr_ptr;
        overflow_n = overflow | (send & full);
        count_n    = count + CNT_W'(push) - CNT_W'(pop);

        case (state)
            IDLE: begin
                if (!empty) begin
                    shift_n  = mem[rd_ptr];
                    rd_ptr_n = rd_ptr + 1'b1;
                    period_n = (baud_div == 16'd0) ? 16'd1 : baud_div;
                    timer_n  = '0;
                    state_n  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    timer_n   = '0;
                    bit_idx_n = '0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_n   = '0;
                    shift_n   = {1'b0, shift[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    timer_n = '0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Line level follows the state being entered, so TxD leaves a flop aligned with state.
        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shift_n[0];
            default: txd_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            shift    <= '0;
            bit_idx  <= '0;
            timer    <= '0;
            period   <= 16'd1;
            TxD      <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            count    <= count_n;
            shift    <= shift_n;
            bit_idx  <= bit_idx_n;
            timer    <= timer_n;
            period   <= period_n;
            TxD      <= txd_n;
            overflow <= overflow_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= send_data;
    end
endmodule

// File: tb/tb_spart_tx_buffer.sv
// tb/tb_spart_tx_buffer.sv - scoreboard bench for spart_tx_buffer with a cycle-exact 8N1 line monitor
module tb_spart_tx_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        send;
    logic [7:0]  send_data;
    logic [15:0] baud_div;
    logic        full, TxD, tx_busy, empty, overflow;
    logic [3:0]  count;

    typedef struct {
        int         p;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    int   start_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   nframes = 0;

    spart_tx_buffer #(.DEPTH(8), .ADDR_W(3), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .send(send), .send_data(send_data), .full(full),
        .baud_div(baud_div), .TxD(TxD), .tx_busy(tx_busy), .empty(empty),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] d, input int p, input bit sent);
        @(posedge clk); #1;
        send = 1'b1;
        send_data = d;
        if (sent) sb.push_back('{p, d});
    endtask

    task automatic release_send();
        @(posedge clk); #1;
        send = 1'b0;
    endtask

    task automatic wait_cycle(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || tx_busy || !empty) && n < budget) begin
            @(negedge clk);
            n++;
        end
        expect_eq("drain_in_budget", n < budget, 1);
        repeat (3) @(negedge clk);
    endtask

    // Line monitor: every cycle of each frame is checked against the expected byte and period.
    initial begin
        logic       prev;
        logic       ok, eb, aborted;
        logic [7:0] data;
        int         bitn;
        exp_t       e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && prev && !TxD) begin
                start_q.push_back(cyc);
                nframes++;
                expect_eq("frame_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    ok = 1'b1;
                    data = '0;
                    aborted = 1'b0;
                    for (int k = 0; k < 10 * e.p; k++) begin
                        if (k > 0) @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        bitn = k / e.p;
                        if (bitn == 0) eb = 1'b0;
                        else if (bitn == 9) eb = 1'b1;
                        else eb = e.d[bitn-1];
                        if (TxD !== eb) ok = 1'b0;
                        if (bitn >= 1 && bitn <= 8 && (k % e.p) == 0) data[bitn-1] = TxD;
                    end
                    if (!aborted) begin
                        expect_eq("rx_byte", data, e.d);
                        expect_eq("rx_frame_timing", ok, 1);
                    end
                end
            end
            prev = TxD;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, t, f0;
        rst = 1'b1;
        send = 1'b0;
        send_data = '0;
        baud_div = 16'd4;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        expect_eq("rst_txd", TxD, 1);
        expect_eq("rst_empty", empty, 1);
        expect_eq("rst_full", full, 0);
        expect_eq("rst_count", count, 0);
        expect_eq("rst_busy", tx_busy, 0);
        expect_eq("rst_overflow", overflow, 0);

        // Single byte 0xA5 at period 4
        start_q.delete();
        push(8'hA5, 4, 1'b1);
        t = cyc;
        release_send();
        @(negedge clk);
        expect_eq("single_count_after_push", count, 1);
        @(negedge clk);
        expect_eq("single_count_after_pop", count, 0);
        expect_eq("single_txd_start", TxD, 0);
        expect_eq("single_busy", tx_busy, 1);
        while (cyc < t + 41) @(negedge clk);
        expect_eq("single_busy_last_stop", tx_busy, 1);
        @(negedge clk);
        expect_eq("single_busy_fall", tx_busy, 0);
        wait_drain(200);
        expect_eq("single_start_cycle", (start_q.size() == 1) ? start_q[0] : -1, t + 2);

        // Fill and overflow at period 100
        baud_div = 16'd100;
        for (int i = 0; i < 10; i++) push(8'(i), 100, i < 9);
        release_send();
        @(negedge clk);
        expect_eq("fill_count", count, 8);
        expect_eq("fill_full", full, 1);
        expect_eq("fill_overflow", overflow, 1);
        wait_drain(12000);
        expect_eq("overflow_sticky", overflow, 1);
        expect_eq("drained_full", full, 0);

        // Simultaneous push and pop at the frame boundary
        baud_div = 16'd4;
        start_q.delete();
        push(8'h11, 4, 1'b1);
        c = cyc;
        push(8'h22, 4, 1'b1);
        push(8'h33, 4, 1'b1);
        push(8'h44, 4, 1'b1);
        release_send();
        wait_cycle(c + 42);
        send = 1'b1;
        send_data = 8'h3C;
        sb.push_back('{4, 8'h3C});
        @(negedge clk);
        expect_eq("pp_idle_cycle", tx_busy, 0);
        expect_eq("pp_count_before", count, 3);
        release_send();
        expect_eq("pp_count_after", count, 3);
        wait_drain(400);
        expect_eq("pp_frames", start_q.size(), 5);
        for (int k = 0; k < 5 && k < start_q.size(); k++)
            expect_eq("pp_start_cycle", start_q[k], c + 2 + 41 * k);

        // baud_div change mid-frame, then zero treated as one
        baud_div = 16'd2;
        start_q.delete();
        push(8'h55, 2, 1'b1);
        c = cyc;
        push(8'hFF, 1, 1'b1);
        release_send();
        wait_cycle(c + 6);
        baud_div = 16'd0;
        wait_drain(200);
        expect_eq("baud_frames", start_q.size(), 2);
        if (start_q.size() == 2) begin
            expect_eq("baud_start0", start_q[0], c + 2);
            expect_eq("baud_start1", start_q[1], c + 23);
        end

        // Reset during DATA bit 3 with four bytes queued
        baud_div = 16'd4;
        push(8'hA1, 4, 1'b1);
        c = cyc;
        for (int i = 2; i <= 5; i++) push(8'hA0 + 8'(i), 4, 1'b1);
        release_send();
        wait_cycle(c + 19);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        expect_eq("midrst_txd", TxD, 1);
        expect_eq("midrst_empty", empty, 1);
        expect_eq("midrst_count", count, 0);
        expect_eq("midrst_busy", tx_busy, 0);
        expect_eq("midrst_overflow", overflow, 0);
        f0 = nframes;
        repeat (100) @(negedge clk);
        expect_eq("midrst_no_frames", nframes, f0);
        expect_eq("midrst_txd_idle", TxD, 1);
        expect_eq("sb_leftover", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spart_tx_buffer.md
Name: spart_tx_buffer

Overview:
- Transmit side of the SPART, directly downstream of the processor's send/send_data/full interface.
- Buffers bytes pushed by the processor in a small FIFO and serializes them onto TxD as 8N1 UART frames at a programmable bit period.
- Drives `full` back to the processor's stall controller so that sends stall instead of being lost.

Parameters:
- DEPTH, 8: FIFO entries; must be a power of two, minimum 2.
- ADDR_W, 3: log2(DEPTH); pointer width.
- CNT_W, 4: ADDR_W+1; occupancy counter width.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- send  input  1  processor push strobe for one byte, sampled each cycle.
- send_data  input  8  byte to push when send=1.
- full  output  1  FIFO holds DEPTH entries; processor must not push.
- baud_div  input  16  bit period in clk cycles; a value of 0 is treated as 1.
- TxD  output  1  serial line, idle high.
- tx_busy  output  1  a frame is in progress (state is not IDLE).
- empty  output  1  FIFO holds 0 entries.
- count  output  CNT_W  current FIFO occupancy.
- overflow  output  1  sticky flag: a push was attempted while full.

Behaviour:
- Reset: rst=1 at a rising edge clears the following, effective the next cycle, including mid-frame:
  - pointers and count to 0, full=0, empty=1;
  - state to IDLE, TxD=1, tx_busy=0, overflow=0;
  - all buffered bytes are discarded.
- full is defined as (count==DEPTH) and empty as (count==0). Both are decoded from registered count, with no combinational path from send.
- Push:
  - if send=1 and full=0, send_data is written at the write pointer, which then increments modulo DEPTH.
  - if send=1 and full=1, the byte is dropped and overflow is set; it stays set until rst.
- Pop: occurs only in IDLE when empty=0, in the same cycle the frame starts.
  - Reads the entry at the read pointer into the shift register and increments the read pointer modulo DEPTH.
  - Latches baud_div (0 becomes 1) into the period register.
  - Enters START.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- Push into an empty FIFO: the byte becomes visible the next cycle. There is no bypass, so the pop happens one cycle after the push at the earliest.
- A write when count==DEPTH-1 with no pop gives full=1 on the next cycle.
- Pointers wrap at DEPTH with no special handling.
- Bit timer: counts 0..period-1, and a bit ends when the timer is at period-1. Changes to baud_div mid-frame have no effect until the next pop.
- State machine:
  - IDLE: TxD=1. If not empty, pop and go to START; otherwise stay in IDLE.
  - START: TxD=0 for period cycles, then go to DATA with bit index 0.
  - DATA: TxD=shift[0] for period cycles per bit, LSB first, shifting right after each bit. After bit 7, go to STOP.
  - STOP: TxD=1 for period cycles, then go to IDLE.
- tx_busy = (state != IDLE).
- Frame timing: TxD falls the cycle after the pop and a frame lasts 10*period cycles.
  - Back-to-back frames have exactly one IDLE cycle between the end of STOP and the next start bit, so TxD is high for period+1 cycles between frames.
- TxD is driven from a register, so it is glitch-free.

Test Plan:
- Reset then idle: rst high 2 cycles, then low → TxD=1, empty=1, full=0, count=0, tx_busy=0, overflow=0.
- Single byte, baud_div=4: push 0xA5 at cycle t.
  - Pop at t+1; TxD=0 during t+2..t+5.
  - Data bits 1,0,1,0,0,1,0,1, each lasting 4 cycles.
  - Stop bit high for 4 cycles; tx_busy falls at t+42.
- Fill and overflow, baud_div=100: push 10 bytes back-to-back 0x00..0x09.
  - The first byte is popped into the shifter, so the FIFO accepts 0x01..0x08 and full=1 after 0x08.
  - Push 0x09 sets overflow=1; count stays 8; the transmitted sequence is 0x00..0x08.
- Simultaneous push/pop: FIFO holds 3 bytes while in IDLE at the end of a frame; push 0x3C in the pop cycle → count stays 3, and 0x3C is sent last.
- baud_div change and zero, baud_div=2: start frame 0x55, then set baud_div=0 mid-frame.
  - The current frame keeps a 2-cycle bit period.
  - The next frame 0xFF uses a 1-cycle bit period (10 cycles total).
- Reset mid-frame: assert rst during DATA bit 3 with 4 bytes queued → TxD=1 and empty=1 the next cycle, and no further frames are sent.
